// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit read and write sequencers.
// Default timings assume a 100 MHz clk.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HI_E,
    HI_GAP,
    LO_E,
    LO_GAP,
    RESP
  } lcd_state_t;

  localparam int LCD_T_SETUP = 4;
  localparam int LCD_T_EHIGH = 25;
  localparam int LCD_T_ELOW  = 30;
  localparam int LCD_CW      = 8;
  // Read data delay tDDR expressed in clk cycles.
  localparam int LCD_T_DDR   = 20;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  function automatic int lcd_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// E-pulse generator: E high for t_high cycles, then low for t_low cycles.
// strike marks E's last high cycle, done marks the last cycle of the low gap.
module lcd_nibble_strobe
  import lcd_pkg::*;
#(
  parameter int CW = LCD_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] t_high,
  input  logic [CW-1:0] t_low,
  output logic          e,
  output logic          strike,
  output logic          done
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic          gap;
  logic [CW-1:0] cnt;
  logic          tc;

  assign tc     = (cnt == '0);
  assign strike = e & tc;
  assign done   = gap & tc;

  // A start on the last gap cycle re-arms E with no idle cycle in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e   <= 1'b0;
      gap <= 1'b0;
      cnt <= '0;
    end else if (e) begin
      if (tc) begin
        e   <= 1'b0;
        gap <= 1'b1;
        cnt <= t_low - ONE;
      end else begin
        cnt <= cnt - ONE;
      end
    end else if (start) begin
      e   <= 1'b1;
      gap <= 1'b0;
      cnt <= t_high - ONE;
    end else if (gap) begin
      if (tc) begin
        gap <= 1'b0;
      end else begin
        cnt <= cnt - ONE;
      end
    end
  end

endmodule

// File: rtl/lcd_reader.sv
// HD44780 4-bit read engine: one BF/AC (rs=0) or data (rs=1) read per request,
// upper nibble first. Define LCD_RD_SYNC_EN to resynchronise DB7..DB4 before capture.
//
// state  | meaning
// IDLE   | ready for a request, pins released
// SETUP  | RS/RW valid with E low (tAS)
// HI_E   | first E pulse, upper nibble captured on its last cycle
// HI_GAP | E low between the two nibbles
// LO_E   | second E pulse, lower nibble captured on its last cycle
// LO_GAP | E low, completes tcycE
// RESP   | one-cycle response pulse, pins released
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int T_SETUP = LCD_T_SETUP,
  parameter int T_EHIGH = LCD_T_EHIGH,
  parameter int T_ELOW  = LCD_T_ELOW,
  parameter int CW      = LCD_CW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_busy,
  output logic       lcd_active,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       lcd_db_oe,
  input  logic [3:0] lcd_db_in
);

  localparam int T_MAX = lcd_max3(T_SETUP, T_EHIGH, T_ELOW);

  logic [3:0] db_cap;

`ifdef LCD_RD_SYNC_EN
  localparam int DDR_MARGIN = 2;

  logic [3:0] db_meta;
  logic [3:0] db_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_meta <= '0;
      db_sync <= '0;
    end else begin
      db_meta <= lcd_db_in;
      db_sync <= db_meta;
    end
  end

  assign db_cap = db_sync;
`else
  localparam int DDR_MARGIN = 0;

  assign db_cap = lcd_db_in;
`endif

  if (T_SETUP < 1 || T_EHIGH < 1 || T_ELOW < 1) begin : g_bad_zero
    $error("lcd_reader: timing parameters must be non-zero");
  end
  if (CW < 1 || 64'(T_MAX) >= (64'd1 << CW)) begin : g_bad_cw
    $error("lcd_reader: CW too narrow for the timing parameters");
  end
  // The sampled nibble must already be valid tDDR after E rose.
  if (T_EHIGH <= LCD_T_DDR + DDR_MARGIN) begin : g_bad_ddr
    $error("lcd_reader: T_EHIGH does not cover tDDR");
  end

  lcd_state_t state;
  logic [CW-1:0] cnt;
  logic          cnt_tc;
  logic          rs_q;
  logic          strobe_start;
  logic          strike;
  logic          strobe_done;

  assign cnt_tc       = (cnt == '0);
  assign strobe_start = ((state == SETUP) && cnt_tc) || ((state == HI_GAP) && strobe_done);
  assign lcd_db_oe    = 1'b0;

  lcd_nibble_strobe #(.CW(CW)) u_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (strobe_start),
    .t_high (CW'(T_EHIGH)),
    .t_low  (CW'(T_ELOW)),
    .e      (lcd_e),
    .strike (strike),
    .done   (strobe_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rs_q       <= LCD_RS_CMD;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_busy   <= 1'b0;
      lcd_active <= 1'b0;
      lcd_rs     <= LCD_RS_CMD;
      lcd_rw     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state      <= SETUP;
            cnt        <= CW'(T_SETUP - 1);
            rs_q       <= req_rs;
            req_ready  <= 1'b0;
            lcd_active <= 1'b1;
            lcd_rs     <= req_rs;
            lcd_rw     <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_tc) begin
            state <= HI_E;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HI_E: begin
          if (strike) begin
            rsp_data[7:4] <= db_cap;
            rsp_busy      <= (rs_q == LCD_RS_DATA) ? 1'b0 : db_cap[3];
            state         <= HI_GAP;
          end
        end
        HI_GAP: begin
          if (strobe_done) begin
            state <= LO_E;
          end
        end
        LO_E: begin
          if (strike) begin
            rsp_data[3:0] <= db_cap;
            state         <= LO_GAP;
          end
        end
        LO_GAP: begin
          if (strobe_done) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            lcd_active <= 1'b0;
            lcd_rs     <= LCD_RS_CMD;
            lcd_rw     <= 1'b0;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: an LCD pin model answers E strobes and a
// queue-based monitor measures pin timing against the expected transaction shape.
module tb_lcd_reader;

  localparam int T_SETUP = 4;
  localparam int T_EHIGH = 25;
  localparam int T_ELOW  = 30;
  localparam int LAT     = 1 + T_SETUP + 2 * T_EHIGH + 2 * T_ELOW;
  localparam int ACTIVE  = T_SETUP + 2 * T_EHIGH + 2 * T_ELOW;

`ifdef LCD_RD_SYNC_EN
  localparam logic [7:0] EXP_LATE = 8'hA3;
`else
  localparam logic [7:0] EXP_LATE = 8'h5C;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_rs;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_busy;
  logic       lcd_active;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic       lcd_db_oe;
  logic [3:0] lcd_db_in;

  always #5 clk = ~clk;

  lcd_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_rs     (req_rs),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_busy   (rsp_busy),
    .lcd_active (lcd_active),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_db_oe  (lcd_db_oe),
    .lcd_db_in  (lcd_db_in)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // LCD model controls
  logic [3:0] m_hi, m_lo;
  logic       m_late;
  logic       mon_rs;

  // Monitor results
  int         cyc = 0;
  int         hi_run = 0, lo_run = 0;
  int         rsrw_bad = 0, act_cycles = 0, oe_bad = 0, act_rises = 0;
  logic       prev_active = 1'b0;
  int         hi_q[$];
  int         lo_q[$];
  int         rsp_t[$];
  logic [7:0] rsp_d[$];

  function automatic logic [8:0] ref_read(input logic rs, input logic [3:0] hi, input logic [3:0] lo);
    logic [7:0] b;
    b = {hi, lo};
    return {(rs ? 1'b0 : b[7]), b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // LCD pin model: junk on DB except near the end of each E pulse.
  initial begin : lcd_model
    int         hi_pos;
    int         pulse_idx;
    logic [3:0] nib;
    hi_pos    = 0;
    pulse_idx = 0;
    lcd_db_in = 4'h0;
    forever begin
      @(negedge clk);
      if (!lcd_active) pulse_idx = 0;
      if (lcd_e) begin
        hi_pos++;
        nib = (pulse_idx == 0) ? m_hi : m_lo;
        if (m_late) lcd_db_in = (hi_pos >= T_EHIGH - 1) ? ~nib : nib;
        else        lcd_db_in = (hi_pos >= T_EHIGH - 5) ? nib : 4'($urandom);
      end else begin
        if (hi_pos != 0) pulse_idx++;
        hi_pos    = 0;
        lcd_db_in = 4'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    if (lcd_e) hi_run++;
    else if (hi_run != 0) begin
      hi_q.push_back(hi_run);
      hi_run = 0;
    end
    if (lcd_active && !lcd_e) lo_run++;
    else if (lo_run != 0) begin
      lo_q.push_back(lo_run);
      lo_run = 0;
    end
    if (lcd_active) begin
      act_cycles++;
      if (lcd_rs !== mon_rs || lcd_rw !== 1'b1) rsrw_bad++;
    end
    if (lcd_e && !lcd_active) rsrw_bad++;
    if (lcd_active && !prev_active) act_rises++;
    prev_active = lcd_active;
    if (lcd_db_oe !== 1'b0) oe_bad++;
    if (rsp_valid) begin
      rsp_t.push_back(cyc);
      rsp_d.push_back(rsp_data);
    end
    cyc++;
  end

  task automatic run_read(input string tag, input logic rs, input logic [3:0] hi,
                          input logic [3:0] lo, input logic [7:0] exp_data, input logic exp_busy);
    int n;
    int w;
    w = 0;
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    m_hi   = hi;
    m_lo   = lo;
    mon_rs = rs;
    hi_q.delete();
    lo_q.delete();
    rsrw_bad   = 0;
    act_cycles = 0;
    req_rs     = rs;
    req_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) req_valid = 1'b0;
    end while (!rsp_valid && n < 2 * LAT);
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, "_busy"}, 32'(rsp_busy), 32'(exp_busy));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [8:0] exp;
    logic       r;
    logic [3:0] h, l;
    int         w;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    m_hi      = 4'h0;
    m_lo      = 4'h0;
    m_late    = 1'b0;
    mon_rs    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(req_ready),  32'd1);
    check("rst_rspv",   32'(rsp_valid),  32'd0);
    check("rst_data",   32'(rsp_data),   32'd0);
    check("rst_busy",   32'(rsp_busy),   32'd0);
    check("rst_active", 32'(lcd_active), 32'd0);
    check("rst_rs",     32'(lcd_rs),     32'd0);
    check("rst_rw",     32'(lcd_rw),     32'd0);
    check("rst_e",      32'(lcd_e),      32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Busy flag / address read with full pin-timing measurement
    oe_bad = 0;
    exp = ref_read(1'b0, 4'h8, 4'h5);
    run_read("bfac", 1'b0, 4'h8, 4'h5, exp[7:0], exp[8]);
    @(negedge clk);
    check("t_hi_n",   32'(hi_q.size()), 32'd2);
    check("t_hi0",    32'(hi_q[0]), 32'(T_EHIGH));
    check("t_hi1",    32'(hi_q[1]), 32'(T_EHIGH));
    check("t_lo_n",   32'(lo_q.size()), 32'd3);
    check("t_setup",  32'(lo_q[0]), 32'(T_SETUP));
    check("t_gap",    32'(lo_q[1]), 32'(T_ELOW));
    check("t_tail",   32'(lo_q[2]), 32'(T_ELOW));
    check("t_rsrw",   32'(rsrw_bad), 32'd0);
    check("t_active", 32'(act_cycles), 32'(ACTIVE));

    // Data read 'A', RS must stay 1 for the whole window
    exp = ref_read(1'b1, 4'h4, 4'h1);
    run_read("data", 1'b1, 4'h4, 4'h1, exp[7:0], exp[8]);
    @(negedge clk);
    check("d_rsrw",   32'(rsrw_bad), 32'd0);
    check("d_active", 32'(act_cycles), 32'(ACTIVE));

    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom);
      h = 4'($urandom);
      l = 4'($urandom);
      exp = ref_read(r, h, l);
      run_read("rnd", r, h, l, exp[7:0], exp[8]);
    end
    @(negedge clk);

    // Held request: accepts spaced by latency+1
    r = 1'($urandom);
    h = 4'($urandom);
    l = 4'($urandom);
    exp = ref_read(r, h, l);
    rsp_t.delete();
    rsp_d.delete();
    act_rises = 0;
    m_hi   = h;
    m_lo   = l;
    mon_rs = r;
    req_rs = r;
    req_valid = 1'b1;
    repeat (200) @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (rsp_t.size() < 2 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (150) @(negedge clk);
    check("held_accepts", 32'(act_rises), 32'd2);
    check("held_rsps",    32'(rsp_t.size()), 32'd2);
    check("held_spacing", 32'(rsp_t[1] - rsp_t[0]), 32'(LAT + 1));
    check("held_data0",   32'(rsp_d[0]), 32'(exp[7:0]));
    check("held_data1",   32'(rsp_d[1]), 32'(exp[7:0]));

    // Reset while E is low between the nibbles
    m_hi = 4'h9;
    m_lo = 4'h6;
    mon_rs = 1'b0;
    req_rs = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!lcd_e && w < 50) begin
      @(negedge clk);
      w++;
    end
    w = 0;
    while (lcd_e && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    check("gap_active", 32'(lcd_active), 32'd1);
    check("gap_rw",     32'(lcd_rw),     32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_e",      32'(lcd_e),      32'd0);
    check("mid_rst_rw",     32'(lcd_rw),     32'd0);
    check("mid_rst_active", 32'(lcd_active), 32'd0);
    check("mid_rst_ready",  32'(req_ready),  32'd1);
    @(negedge clk);
    rsp_t.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("mid_rst_no_rsp", 32'(rsp_t.size()), 32'd0);
    exp = ref_read(1'b0, 4'h3, 4'hC);
    run_read("after_rst", 1'b0, 4'h3, 4'hC, exp[7:0], exp[8]);

    // DB changes one cycle before E's last high cycle
    m_late = 1'b1;
    run_read("late", 1'b1, 4'hA, 4'h3, EXP_LATE, 1'b0);
    m_late = 1'b0;
    @(negedge clk);
    check("db_oe", 32'(oe_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
